uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver that generalises the fixed 8N1 receiver: configurable data width, optional parity, one or two stop bits, false-start rejection, error flags and a valid/ack output handshake with overrun detection. It sits between the board RX pin and the SPI/command logic. Data and status are held in an output register until the consumer acknowledges them.

## Interface
- G_FREQ_CLK, 10**8: clock frequency in Hz.
- G_BAUD, 9600: baud rate.
- G_DATA_BITS, 8: data bits per frame, legal range 5..9.
- G_STOP_BITS, 1: stop bits, 1 or 2.
- G_PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when the parity macro is defined.
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  system clock.
- uart_rx  in  1  asynchronous serial line, idle high.
- receiving  out  1  high while a frame is in progress (START through STOP).
- dat_valid  out  1  output register holds an unconsumed frame.
- dat_ack  in  1  consumer takes the frame; ignored when dat_valid=0.
- dat_o  out  G_DATA_BITS  received data, LSB first on the line.
- frame_err  out  1  a stop bit was sampled as 0; qualified by dat_valid.
- parity_err  out  1  parity mismatch; qualified by dat_valid.
- overrun  out  1  one-cycle pulse: a frame was overwritten before it was acknowledged.

## Operation
- Input path: 2-FF synchroniser, then a `prev` register. All three reset to 0.
- Start condition: `prev`=1 and synchronised line=0. A line held low through reset release does not start a frame.
- Divider: C_DIV_END = G_FREQ_CLK/G_BAUD-1 and C_HALF = C_DIV_END/2. The counter runs 0..C_DIV_END and wraps.
  - The sample point is count==C_HALF.
  - The bit boundary is count==C_DIV_END.
  - The counter is cleared in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on start condition, go to START with count=0.
- START: at the sample point:
  - line=1: false start, return to IDLE.
  - line=0: at the bit boundary, go to DATA.
- DATA: at each sample point, shift the line into the MSB of a G_DATA_BITS shift register (so bits land LSB first). After the G_DATA_BITS-th boundary, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: at the sample point, compute the error as XOR(data, parity bit, G_PARITY_ODD). At the boundary, go to STOP.
- STOP:
  - Sample each stop bit; any 0 sets frame_err for this frame.
  - At the sample point of the last stop bit, load the output register and return to IDLE immediately, without waiting for the bit end. This allows back-to-back frames.
- Output register load:
  - dat_o, frame_err and parity_err update together; dat_valid is set.
  - If dat_valid was already 1 and dat_ack is not asserted in the same cycle, pulse overrun. The new frame overwrites the old one.
- Handshake: dat_valid clears on the cycle after dat_ack=1. Load and ack in the same cycle: dat_valid stays 1, new data is presented, no overrun.
- Line held low after a frame-error frame (break): no new frame starts until the line has been seen high.

## Timing
- Reset values:
  - receiving=0, dat_valid=0, dat_o=0, frame_err=0, parity_err=0, overrun=0.
  - FSM in IDLE, counter=0.
- Reset mid-frame discards the frame completely. No partial output.
- Latency from the start edge at the synchroniser input to dat_valid=1:
  - 3 + (N-1)·(C_DIV_END+1) + C_HALF + 1 clocks.
  - N = 1 + G_DATA_BITS + P + G_STOP_BITS, where P=1 if parity is compiled in, else 0.
- receiving rises one clock after the start condition and falls in the cycle dat_valid rises.
- Compile-time requirements: C_DIV_END ≥ 3; G_DATA_BITS in 5..9; G_STOP_BITS in 1..2. Violations are reported as elaboration errors.

## Configuration
- UART_RX_PARITY_EN
  - Defined: the PARITY state exists, the frame carries one parity bit, and parity_err is computed using G_PARITY_ODD.
  - Undefined: the PARITY state and its logic are removed, frames carry no parity bit, parity_err is tied to 0, and G_PARITY_ODD is ignored.

## Test plan
All scenarios use G_FREQ_CLK=1_000_000 and G_BAUD=100_000 (10 clk/bit), 8 data bits, 1 stop bit, macro undefined unless stated.
- Send 0xA5 (8N1) and hold dat_ack=0 → dat_valid=1 at the computed latency, dat_o=0xA5, both error flags 0, dat_valid held until dat_ack, cleared one clock after it.
- Drive a 3-clock low glitch → receiving pulses; dat_valid stays 0; the next proper frame 0x3C is received correctly.
- Send 0x00 with stop bit 0, then hold the line low for 30 bit times → exactly one frame with frame_err=1 and dat_o=0x00; no further frames until the line goes high and a new start arrives.
- Send 0x11 then 0x22 back to back with no ack → overrun pulses for 1 clock when the second frame loads; dat_o=0x22.
- With UART_RX_PARITY_EN and G_PARITY_ODD=0:
  - 0x07 with parity bit 1 → parity_err=0.
  - 0x07 with parity bit 0 → parity_err=1.
- Assert rst after the 4th data bit of 0xFF, release, then send 0x5A → no output for the aborted frame; 0x5A is received clean.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, 1/2 stop bits, parity via UART_RX_PARITY_EN); loads its output mid last stop bit.
// dat_valid holds each frame until dat_ack; a newer frame overwrites an unacknowledged one and pulses overrun.
module uart_rx_cfg #(
   parameter int G_FREQ_CLK   = 10**8,
   parameter int G_BAUD       = 9600,
   parameter int G_DATA_BITS  = 8,
   parameter int G_STOP_BITS  = 1,
   parameter int G_PARITY_ODD = 0
) (
   input  logic                   rst,
   input  logic                   clk,
   input  logic                   uart_rx,
   output logic                   receiving,
   output logic                   dat_valid,
   input  logic                   dat_ack,
   output logic [G_DATA_BITS-1:0] dat_o,
   output logic                   frame_err,
   output logic                   parity_err,
   output logic                   overrun
);

   localparam int C_DIV_END = G_FREQ_CLK / G_BAUD - 1;
   localparam int C_HALF    = C_DIV_END / 2;
   localparam int C_CW      = $clog2(C_DIV_END + 1);
   localparam logic [C_CW-1:0] C_END_V  = C_CW'(C_DIV_END);
   localparam logic [C_CW-1:0] C_HALF_V = C_CW'(C_HALF);
   localparam logic [3:0] C_LAST_DATA = 4'(G_DATA_BITS - 1);
   localparam logic [3:0] C_LAST_STOP = 4'(G_STOP_BITS - 1);

   if (C_DIV_END < 3) begin : g_bad_div
      $error("uart_rx_cfg: G_FREQ_CLK/G_BAUD gives C_DIV_END < 3");
   end
   if (G_DATA_BITS < 5 || G_DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_cfg: G_DATA_BITS must be 5..9");
   end
   if (G_STOP_BITS < 1 || G_STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: G_STOP_BITS must be 1 or 2");
   end
   if (G_PARITY_ODD != 0 && G_PARITY_ODD != 1) begin : g_bad_par
      $error("uart_rx_cfg: G_PARITY_ODD must be 0 or 1");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic C_ODD = (G_PARITY_ODD != 0);
   logic perr_q, perr_d, perr_o_q, perr_o_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [C_CW-1:0]        cnt_q, cnt_d;
   logic [3:0]             bit_q, bit_d;
   logic [G_DATA_BITS-1:0] shift_q, shift_d;
   logic                   ferr_q, ferr_d;
   logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [G_DATA_BITS-1:0] dat_q, dat_d;
   logic                   ferr_o_q, ferr_o_d;
   logic                   vld_q, vld_d;
   logic                   ovr_q, ovr_d;
   logic                   line, start_cond, at_sample, at_end, load;

   // Falling edge needs a previously seen high, so a line stuck low never starts a frame.
   assign line       = sync2_q;
   assign start_cond = prev_q & ~sync2_q;
   assign at_sample  = (cnt_q == C_HALF_V);
   assign at_end     = (cnt_q == C_END_V);

   always_comb begin
      sync1_d  = uart_rx;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      state_d  = state_q;
      cnt_d    = at_end ? '0 : cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      ferr_d   = ferr_q;
`ifdef UART_RX_PARITY_EN
      perr_d   = perr_q;
`endif
      load     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_cond) begin
               state_d = S_START;
               bit_d   = '0;
               ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         S_START: begin
            if (at_sample && line) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (at_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (at_sample) shift_d = {line, shift_q[G_DATA_BITS-1:1]};
            if (at_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == C_LAST_DATA) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (at_sample) perr_d = (^shift_q) ^ line ^ C_ODD;
            if (at_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (at_sample) begin
               if (!line) ferr_d = 1'b1;
               // Leave at the last stop sample so a back-to-back start edge is not missed.
               if (bit_q == C_LAST_STOP) begin
                  load    = 1'b1;
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else if (at_end) begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      dat_d    = dat_q;
      ferr_o_d = ferr_o_q;
`ifdef UART_RX_PARITY_EN
      perr_o_d = perr_o_q;
`endif
      vld_d    = vld_q & ~dat_ack;
      ovr_d    = 1'b0;
      if (load) begin
         dat_d    = shift_q;
         ferr_o_d = ferr_q | ~line;
`ifdef UART_RX_PARITY_EN
         perr_o_d = perr_q;
`endif
         vld_d    = 1'b1;
         ovr_d    = vld_q & ~dat_ack;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         ferr_q   <= 1'b0;
         dat_q    <= '0;
         ferr_o_q <= 1'b0;
         vld_q    <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q   <= 1'b0;
         perr_o_q <= 1'b0;
`endif
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         ferr_q   <= ferr_d;
         dat_q    <= dat_d;
         ferr_o_q <= ferr_o_d;
         vld_q    <= vld_d;
         ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
         perr_q   <= perr_d;
         perr_o_q <= perr_o_d;
`endif
      end
   end

   assign receiving = (state_q != S_IDLE);
   assign dat_valid = vld_q;
   assign dat_o     = dat_q;
   assign frame_err = ferr_o_q;
   assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_o_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg at 10 clocks per bit: frames are built from bit lists, results compared against a queue of expected frames.
module tb_uart_rx_cfg;

   localparam int FREQ     = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int DB       = 8;
   localparam int SB       = 1;
   localparam int ODD      = 0;
   localparam int BIT_CLKS = FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS  = 1 + DB + PB + SB;
   localparam int LAT    = 3 + (NBITS - 1) * BIT_CLKS + (BIT_CLKS - 1) / 2 + 1;
   localparam int LD_OFS = LAT - (NBITS - 1) * BIT_CLKS;

   typedef struct packed {
      logic [DB-1:0] dat;
      logic          ferr;
      logic          perr;
      logic [31:0]   cyc;
      logic          rcv;
   } rec_t;

   logic          clk;
   logic          rst;
   logic          uart_rx;
   logic          dat_ack;
   logic          receiving;
   logic          dat_valid;
   logic [DB-1:0] dat_o;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   rcv_rises = 0;
   int   rcv_rise_cyc = 0;
   int   ovr_cnt = 0;
   int   exp_ovr = 0;
   bit   model_vld = 1'b0;
   logic vld_prev = 1'b0;
   logic rcv_prev = 1'b0;
   rec_t got_q[$];
   rec_t exp_q[$];

   uart_rx_cfg #(
      .G_FREQ_CLK  (FREQ),
      .G_BAUD      (BAUD),
      .G_DATA_BITS (DB),
      .G_STOP_BITS (SB),
      .G_PARITY_ODD(ODD)
   ) dut (
      .rst       (rst),
      .clk       (clk),
      .uart_rx   (uart_rx),
      .receiving (receiving),
      .dat_valid (dat_valid),
      .dat_ack   (dat_ack),
      .dat_o     (dat_o),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .overrun   (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // A load is visible either as a dat_valid rise or as an overrun pulse.
   always @(negedge clk) begin
      if (rst) begin
         vld_prev <= 1'b0;
         rcv_prev <= 1'b0;
      end else begin
         if ((dat_valid && !vld_prev) || overrun)
            got_q.push_back('{dat: dat_o, ferr: frame_err, perr: parity_err, cyc: 32'(cyc), rcv: receiving});
         if (overrun) ovr_cnt <= ovr_cnt + 1;
         if (receiving && !rcv_prev) begin
            rcv_rises    <= rcv_rises + 1;
            rcv_rise_cyc <= cyc;
         end
         vld_prev <= dat_valid;
         rcv_prev <= receiving;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic par_good(input logic [DB-1:0] d);
      return logic'((($countones(d) + ODD) % 2) != 0);
   endfunction

   // Drives one frame starting at a negedge; ack_at = clock index within the last bit to pulse dat_ack (-1: none).
   task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop_ok, input int ack_at);
      logic [NBITS-1:0] bits;
      rec_t e;
      bits    = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < DB; k++) bits[1+k] = d[k];
      if (PB == 1) bits[1+DB] = par;
      for (int s = 0; s < SB; s++) bits[1+DB+PB+s] = stop_ok;
      e.dat  = d;
      e.ferr = ~stop_ok;
      e.perr = (PB == 1) ? logic'((($countones(d) + int'(par)) % 2) != ODD) : 1'b0;
      e.cyc  = 32'(cyc + LAT);
      e.rcv  = 1'b0;
      exp_q.push_back(e);
      if (model_vld && ack_at != LD_OFS - 1) exp_ovr++;
      model_vld = !(ack_at >= LD_OFS);
      for (int b = 0; b < NBITS; b++) begin
         uart_rx = bits[b];
         for (int i = 0; i < BIT_CLKS; i++) begin
            if (b == NBITS - 1 && i == ack_at) dat_ack = 1'b1;
            @(negedge clk);
            dat_ack = 1'b0;
         end
      end
   endtask

   task automatic ack_pulse();
      dat_ack = 1'b1;
      @(negedge clk);
      dat_ack   = 1'b0;
      model_vld = 1'b0;
   endtask

   task automatic sb_compare(input string tag);
      rec_t g, e;
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_dat"},  32'(g.dat),  32'(e.dat));
         chk({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
         chk({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
         chk({tag, "_lat"},  g.cyc,       e.cyc);
         chk({tag, "_rcv"},  32'(g.rcv),  32'(e.rcv));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, r0, o0, eo0;
      logic [DB-1:0] d;
      logic so;
      int ack_sel;

      rst = 1'b1; uart_rx = 1'b0; dat_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(dat_valid), 32'd0);
      chk("rst_recv",  32'(receiving), 32'd0);
      chk("rst_dat",   32'(dat_o),     32'd0);
      chk("rst_ferr",  32'(frame_err), 32'd0);
      chk("rst_perr",  32'(parity_err), 32'd0);
      chk("rst_ovr",   32'(overrun),   32'd0);

      // Line low across reset release must not start a frame.
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("low_at_rst_recv", 32'(rcv_rises), 32'd0);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);

      // Basic frame, latency, hold and ack.
      c0 = cyc;
      send_frame(8'hA5, par_good(8'hA5), 1'b1, -1);
      chk("a5_recv_rise", 32'(rcv_rise_cyc), 32'(c0 + 3));
      sb_compare("a5");
      repeat (20) @(negedge clk);
      chk("a5_hold", 32'(dat_valid), 32'd1);
      ack_pulse();
      chk("a5_ack_clear", 32'(dat_valid), 32'd0);

      // 3-clock glitch is a false start.
      r0 = rcv_rises;
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_recv_pulse", 32'(rcv_rises - r0), 32'd1);
      chk("glitch_no_valid", 32'(dat_valid), 32'd0);
      send_frame(8'h3C, par_good(8'h3C), 1'b1, 9);
      sb_compare("after_glitch");

      // Frame error followed by a break.
      r0 = rcv_rises;
      send_frame(8'h00, par_good(8'h00), 1'b0, -1);
      repeat (30 * BIT_CLKS) @(negedge clk);
      sb_compare("break");
      chk("break_one_frame", 32'(rcv_rises - r0), 32'd1);
      ack_pulse();
      uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h81, par_good(8'h81), 1'b1, 9);
      sb_compare("after_break");

      // Back-to-back frames without ack: overrun.
      o0 = ovr_cnt;
      send_frame(8'h11, par_good(8'h11), 1'b1, -1);
      send_frame(8'h22, par_good(8'h22), 1'b1, -1);
      sb_compare("ovr");
      chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
      chk("ovr_dat", 32'(dat_o), 32'h22);
      ack_pulse();

      // Load and ack in the same cycle: no overrun, new data stays valid.
      o0 = ovr_cnt;
      send_frame(8'h33, par_good(8'h33), 1'b1, -1);
      send_frame(8'h44, par_good(8'h44), 1'b1, LD_OFS - 1);
      void'(exp_q.pop_back());
      sb_compare("ldack");
      chk("ldack_valid", 32'(dat_valid), 32'd1);
      chk("ldack_dat", 32'(dat_o), 32'h44);
      chk("ldack_no_ovr", 32'(ovr_cnt - o0), 32'd0);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 9);
      sb_compare("par_ok");
      chk("par_ok_flag", 32'(parity_err), 32'd0);
      send_frame(8'h07, 1'b0, 1'b1, 9);
      sb_compare("par_bad");
      chk("par_bad_flag", 32'(parity_err), 32'd1);
`endif

      // Reset after the 4th data bit of 0xFF.
      uart_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4 * BIT_CLKS) @(negedge clk);
      chk("midrst_in_frame", 32'(receiving), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_recv", 32'(receiving), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_vld = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_out", 32'(got_q.size()), 32'd0);
      chk("midrst_valid", 32'(dat_valid), 32'd0);
      send_frame(8'h5A, par_good(8'h5A), 1'b1, 9);
      sb_compare("after_rst");

      // Randomized frames, stop errors, gaps and ack choices.
      o0  = ovr_cnt;
      eo0 = exp_ovr;
      for (int n = 0; n < 24; n++) begin
         d       = DB'($urandom);
         so      = ($urandom_range(0, 3) != 0);
         ack_sel = ($urandom_range(0, 1) == 1) ? 9 : -1;
         send_frame(d, (PB == 1) ? logic'($urandom_range(0, 1)) : par_good(d), so, ack_sel);
         uart_rx = 1'b1;
         repeat (so ? $urandom_range(0, 5) : $urandom_range(1, 6)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      sb_compare("rnd");
      chk("rnd_ovr", 32'(ovr_cnt - o0), 32'(exp_ovr - eo0));
      ack_pulse();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
